// File: rtl/crypto_reg_bank.sv
// rtl/crypto_reg_bank.sv - lockable, byte-writable register bank with read protection and zeroize
module crypto_reg_bank #(
  parameter int                  DATA_WIDTH  = 256,
  parameter int                  NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0] SECRET_MASK = NUM_REGS'(16'h0006),
  localparam int                 ADDR_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    writeValid,
  input  logic                    writeLock,
  input  logic [ADDR_WIDTH-1:0]   selectWrite,
  input  logic [DATA_WIDTH-1:0]   writeBus,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  output logic                    writeReady,
  output logic                    writeError,
  input  logic                    readValid,
  input  logic [ADDR_WIDTH-1:0]   selectRead,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    readDone,
  input  logic                    zeroizeReq,
  output logic                    busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {IDLE, ZEROIZE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [NUM_REGS-1:0]     lock;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic wr_in_range, rd_in_range, wr_attempt, wr_bad, wr_accept, rd_zero;

  always_comb begin
    wr_in_range = 32'(selectWrite) < 32'(NUM_REGS);
    rd_in_range = 32'(selectRead) < 32'(NUM_REGS);
    wr_attempt  = writeValid && writeReady;
    wr_bad      = !wr_in_range || lock[selectWrite];
    wr_accept   = wr_attempt && !wr_bad;
    // Protected, out-of-range and mid-zeroize reads all complete but carry no data
    rd_zero     = busy || !rd_in_range || SECRET_MASK[selectRead];
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state      <= IDLE;
      cnt        <= '0;
      lock       <= '0;
      busy       <= 1'b0;
      writeReady <= 1'b1;
      writeError <= 1'b0;
      readDone   <= 1'b0;
      dataOut    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      writeError <= wr_attempt && wr_bad;
      readDone   <= readValid;
      if (readValid) dataOut <= rd_zero ? '0 : regs[selectRead];

      if (wr_accept) begin
        for (int b = 0; b < BYTES; b++)
          if (byteEnable[b]) regs[selectWrite][8*b +: 8] <= writeBus[8*b +: 8];
        if (writeLock) lock[selectWrite] <= 1'b1;
      end

      // A write accepted alongside zeroizeReq lands first; the sweep clears it later
      case (state)
        IDLE: begin
          if (zeroizeReq) begin
            state      <= ZEROIZE;
            cnt        <= '0;
            busy       <= 1'b1;
            writeReady <= 1'b0;
          end
        end
        ZEROIZE: begin
          regs[cnt] <= '0;
          lock[cnt] <= 1'b0;
          if (cnt == LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            writeReady <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_reg_bank.sv
// tb/tb_crypto_reg_bank.sv - directed plus randomized checks of crypto_reg_bank against a behavioural model
module tb_crypto_reg_bank;
  localparam int DW = 256;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int BW = DW / 8;
  localparam logic [NR-1:0] SMASK = 16'h0006;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          writeValid = 1'b0, writeLock = 1'b0, readValid = 1'b0, zeroizeReq = 1'b0;
  logic [AW-1:0] selectWrite = '0, selectRead = '0;
  logic [DW-1:0] writeBus = '0;
  logic [BW-1:0] byteEnable = '0;
  logic          writeReady, writeError, readDone, busy;
  logic [DW-1:0] dataOut;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_lock [NR];
  int            m_zleft = 0;
  logic [DW-1:0] e_data = '0;
  bit            e_done = 1'b0, e_err = 1'b0;

  crypto_reg_bank dut (
    .clock(clock), .resetN(resetN),
    .writeValid(writeValid), .writeLock(writeLock), .selectWrite(selectWrite),
    .writeBus(writeBus), .byteEnable(byteEnable),
    .writeReady(writeReady), .writeError(writeError),
    .readValid(readValid), .selectRead(selectRead),
    .dataOut(dataOut), .readDone(readDone),
    .zeroizeReq(zeroizeReq), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_inputs();
    writeValid = 1'b0; writeLock = 1'b0; readValid = 1'b0; zeroizeReq = 1'b0; byteEnable = '0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be, input bit lk);
    writeValid = 1'b1; selectWrite = AW'(a); writeBus = d; byteEnable = be; writeLock = lk;
  endtask

  task automatic rd(input int a);
    readValid = 1'b1; selectRead = AW'(a);
  endtask

  // Update the model from the inputs present at the coming edge, then compare all outputs after it
  task automatic tick(input string tag);
    bit ready;
    int a;
    ready = (m_zleft == 0);
    if (!resetN) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_lock[i] = 1'b0; end
      m_zleft = 0; e_data = '0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_err  = writeValid && ready && (int'(selectWrite) >= NR || m_lock[selectWrite]);
      e_done = readValid;
      if (readValid) e_data = (!ready || SMASK[selectRead]) ? '0 : m_regs[selectRead];
      if (writeValid && ready && !m_lock[selectWrite]) begin
        for (int b = 0; b < BW; b++)
          if (byteEnable[b]) m_regs[selectWrite][8*b +: 8] = writeBus[8*b +: 8];
        if (writeLock) m_lock[selectWrite] = 1'b1;
      end
      if (m_zleft > 0) begin
        a = NR - m_zleft;
        m_regs[a] = '0; m_lock[a] = 1'b0; m_zleft--;
      end else if (zeroizeReq) begin
        m_zleft = NR;
      end
    end
    @(posedge clock); #1;
    chk({tag, ".data"},  dataOut,            e_data);
    chk({tag, ".done"},  DW'(readDone),      DW'(e_done));
    chk({tag, ".err"},   DW'(writeError),    DW'(e_err));
    chk({tag, ".busy"},  DW'(busy),          DW'(m_zleft > 0));
    chk({tag, ".ready"}, DW'(writeReady),    DW'(m_zleft == 0));
  endtask

  logic [DW-1:0] ones_low00;
  int n_busy;

  initial begin
    ones_low00 = ~(DW'(8'hFF));
    idle_inputs(); resetN = 1'b0;
    tick("rst0"); tick("rst1");
    chk("rst.ready", DW'(writeReady), DW'(1));
    resetN = 1'b1;

    idle_inputs(); wr(3, DW'(4), '1, 1'b0); tick("w3");
    idle_inputs(); rd(3); tick("r3");
    chk("r3.value", dataOut, DW'(4));
    chk("r3.latency", DW'(readDone), DW'(1));
    idle_inputs(); tick("r3.after");
    chk("r3.pulse", DW'(readDone), DW'(0));
    chk("r3.hold", dataOut, DW'(4));

    idle_inputs(); wr(5, '1, '1, 1'b0); tick("w5a");
    idle_inputs(); wr(5, '0, BW'(1), 1'b0); tick("w5b");
    idle_inputs(); rd(5); tick("r5");
    chk("r5.bytemask", dataOut, ones_low00);

    idle_inputs(); wr(1, DW'(8'hAB), '1, 1'b1); tick("w1lock");
    chk("w1lock.err", DW'(writeError), DW'(0));
    idle_inputs(); wr(1, DW'(8'hCD), '1, 1'b0); tick("w1again");
    chk("w1again.err", DW'(writeError), DW'(1));
    idle_inputs(); rd(1); tick("r1");
    chk("r1.secret", dataOut, DW'(0));
    chk("r1.errpulse", DW'(writeError), DW'(0));

    idle_inputs(); wr(8, DW'(8'h5A), '1, 1'b1); tick("w8lock");
    idle_inputs(); wr(8, DW'(8'h77), '1, 1'b0); rd(8); tick("w8again");
    chk("w8again.err", DW'(writeError), DW'(1));
    chk("w8again.data", dataOut, DW'(8'h5A));

    idle_inputs(); wr(7, DW'(8'h11), '1, 1'b0); tick("w7");
    idle_inputs(); wr(7, DW'(8'h22), '1, 1'b0); rd(7); tick("rw7");
    chk("rw7.old", dataOut, DW'(8'h11));
    idle_inputs(); rd(7); tick("r7");
    chk("r7.new", dataOut, DW'(8'h22));

    for (int i = 0; i < 300; i++) begin
      idle_inputs();
      if ($urandom_range(1, 0) == 1)
        wr($urandom_range(NR - 1, 0), rnd_word(), BW'({$urandom, $urandom}), $urandom_range(15, 0) == 0);
      if ($urandom_range(1, 0) == 1) rd($urandom_range(NR - 1, 0));
      zeroizeReq = ($urandom_range(39, 0) == 0);
      tick("rnd");
    end
    idle_inputs();
    for (int i = 0; i < NR + 2; i++) tick("drain");

    for (int a = 0; a < NR; a++) begin
      idle_inputs(); wr(a, rnd_word() | DW'(1), '1, a == 9); tick("fill");
    end
    idle_inputs(); wr(4, DW'(8'h44), '1, 1'b0); zeroizeReq = 1'b1; tick("zstart");
    n_busy = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < NR; i++) begin
      idle_inputs(); wr(i, DW'(8'h99), '1, 1'b0); rd(i); zeroizeReq = (i == 3);
      tick("zrun");
      chk("zrun.readzero", dataOut, DW'(0));
      chk("zrun.noerr", DW'(writeError), DW'(0));
      if (busy === 1'b1) n_busy++;
    end
    chk("zero.busycycles", DW'(n_busy), DW'(NR));
    for (int a = 0; a < NR; a++) begin
      idle_inputs(); rd(a); tick("zcheck");
      chk("zcheck.cleared", dataOut, DW'(0));
    end
    idle_inputs(); wr(9, DW'(8'h3C), '1, 1'b0); tick("w9unlocked");
    chk("w9unlocked.err", DW'(writeError), DW'(0));
    idle_inputs(); rd(9); tick("r9");
    chk("r9.value", dataOut, DW'(8'h3C));

    idle_inputs(); wr(2, DW'(8'h66), '1, 1'b0); rd(9); tick("pre");
    idle_inputs(); zeroizeReq = 1'b1; tick("z2start");
    idle_inputs();
    for (int i = 0; i < 5; i++) tick("z2run");
    resetN = 1'b0; tick("z2reset");
    chk("z2reset.busy", DW'(busy), DW'(0));
    chk("z2reset.data", dataOut, DW'(0));
    chk("z2reset.ready", DW'(writeReady), DW'(1));
    resetN = 1'b1; idle_inputs(); rd(9); tick("z2after");
    chk("z2after.ready", DW'(writeReady), DW'(1));
    chk("z2after.cleared", dataOut, DW'(0));
    idle_inputs(); tick("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
